// File: rtl/data_mem_responder_if.sv
// Load/store request/response bus between a datapath (master) and the data
// memory responder (slave), plus the test-finish status outputs.
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        done;
  logic [31:0] done_code;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_wstrb,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error, done, done_code
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_wstrb,
    output req_ready, rsp_valid, rsp_rdata, rsp_error, done, done_code
  );
endinterface

// File: rtl/data_mem_responder.sv
// Word-addressed data memory with fixed wait states, single-cycle response
// pulse, fault detection and a memory-mapped test-finish register.
module data_mem_responder #(
  parameter int unsigned NUM_BLOCKS  = 128,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned DONE_ADDR   = 100
) (
  input logic                 clk,
  input logic                 rst,
  data_mem_responder_if.slave bus
);

  localparam int unsigned IDX_W     = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
  localparam logic [31:0] MEM_BYTES = 32'(4 * NUM_BLOCKS);
  localparam logic [31:0] DONE_A    = 32'(DONE_ADDR);
  localparam logic [3:0]  CNT_LOAD  = 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        write_q, write_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_error_q, rsp_error_d;
  logic        done_q, done_d;
  logic [31:0] done_code_q, done_code_d;
  logic [31:0] mem_q [NUM_BLOCKS];

  logic             ready_s, enter_resp_s, mem_we_s, fault_s, is_done_s;
  logic             acc_write_s;
  logic [31:0]      acc_addr_s, acc_wdata_s;
  logic [3:0]       acc_wstrb_s;
  logic [IDX_W-1:0] widx_s;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_w;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) begin
        res[8*b +: 8] = new_w[8*b +: 8];
      end else begin
        res[8*b +: 8] = old_w[8*b +: 8];
      end
    end
    return res;
  endfunction

  assign ready_s = rst && (state_q == ST_IDLE);

  // With zero wait states the access happens on the accept edge, so use the live bus.
  assign acc_write_s = (state_q == ST_IDLE) ? bus.req_write : write_q;
  assign acc_addr_s  = (state_q == ST_IDLE) ? bus.req_addr  : addr_q;
  assign acc_wdata_s = (state_q == ST_IDLE) ? bus.req_wdata : wdata_q;
  assign acc_wstrb_s = (state_q == ST_IDLE) ? bus.req_wstrb : wstrb_q;

  assign fault_s   = (acc_addr_s[1:0] != 2'b00) ||
                     ((acc_addr_s >= MEM_BYTES) && (acc_addr_s != DONE_A));
  assign is_done_s = !fault_s && (acc_addr_s == DONE_A);
  assign widx_s    = acc_addr_s[IDX_W+1:2];

  // Next-state, request latching and access/response computation.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    write_d      = write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    rsp_valid_d  = 1'b0;
    rsp_rdata_d  = 32'd0;
    rsp_error_d  = 1'b0;
    done_d       = done_q;
    done_code_d  = done_code_q;
    mem_we_s     = 1'b0;
    enter_resp_s = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          write_d = bus.req_write;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          wstrb_d = bus.req_wstrb;
          if (WAIT_CYCLES == 0) begin
            state_d      = ST_RESP;
            enter_resp_s = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_LOAD;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d      = ST_RESP;
          enter_resp_s = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (enter_resp_s) begin
      rsp_valid_d = 1'b1;
      if (fault_s) begin
        rsp_error_d = 1'b1;
      end else if (acc_write_s) begin
        if (is_done_s) begin
          done_d      = 1'b1;
          done_code_d = acc_wdata_s;
        end else begin
          mem_we_s = 1'b1;
        end
      end else if (is_done_s) begin
        rsp_rdata_d = done_code_q;
      end else begin
        rsp_rdata_d = mem_q[widx_s];
      end
    end else begin
      rsp_valid_d = 1'b0;
    end
  end

  // Control and response registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      write_q     <= 1'b0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      wstrb_q     <= 4'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_error_q <= 1'b0;
      done_q      <= 1'b0;
      done_code_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
      done_q      <= done_d;
      done_code_q <= done_code_d;
    end
  end

  // Backing storage survives reset; a reset edge suppresses any pending commit.
  always_ff @(posedge clk) begin
    if (rst && mem_we_s) begin
      mem_q[widx_s] <= merge_bytes(mem_q[widx_s], acc_wdata_s, acc_wstrb_s);
    end
  end

  assign bus.req_ready = ready_s;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_error = rsp_error_q;
  assign bus.done      = done_q;
  assign bus.done_code = done_code_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench: a WAIT_CYCLES=2 instance for function/latency
// and a WAIT_CYCLES=0 instance for back-to-back throughput.
module tb_data_mem_responder;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  data_mem_responder_if bus0 ();
  data_mem_responder_if bus1 ();

  data_mem_responder #(.NUM_BLOCKS(128), .WAIT_CYCLES(2), .DONE_ADDR(100)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0.slave)
  );

  data_mem_responder #(.NUM_BLOCKS(128), .WAIT_CYCLES(0), .DONE_ADDR(100)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One full transaction on bus0; returns response data, error and latency
  // in cycles (the cycle right after the accept edge counts as 1).
  task automatic access(input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] rdata,
                        output logic err, output int lat);
    int n;
    bit seen;
    @(negedge clk);
    bus0.req_valid = 1'b1;
    bus0.req_write = wr;
    bus0.req_addr  = a;
    bus0.req_wdata = d;
    bus0.req_wstrb = s;
    n = 0;
    while (!bus0.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("accept_ready", {31'd0, bus0.req_ready}, 32'd1);
    @(posedge clk);
    #1;
    bus0.req_valid = 1'b0;
    bus0.req_addr  = 32'hFFFF_FFFF;
    bus0.req_wdata = 32'h0BAD_0BAD;
    lat  = 1;
    seen = 1'b0;
    while (!seen && lat <= 20) begin
      if (bus0.rsp_valid) begin
        seen = 1'b1;
      end else begin
        @(posedge clk);
        #1;
        lat++;
      end
    end
    check_eq("rsp_seen", {31'd0, seen}, 32'd1);
    rdata = bus0.rsp_rdata;
    err   = bus0.rsp_error;
    @(posedge clk);
    #1;
    check_eq("rsp_one_cycle", {31'd0, bus0.rsp_valid}, 32'd0);
    check_eq("rdata_idle_zero", bus0.rsp_rdata, 32'd0);
  endtask

  logic [31:0] rd;
  logic        er;
  int          lt;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b0;
    bus0.req_valid = 1'b0; bus0.req_write = 1'b0; bus0.req_addr = 32'd0;
    bus0.req_wdata = 32'd0; bus0.req_wstrb = 4'd0;
    bus1.req_valid = 1'b0; bus1.req_write = 1'b0; bus1.req_addr = 32'd0;
    bus1.req_wdata = 32'd0; bus1.req_wstrb = 4'd0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_ready", {31'd0, bus0.req_ready}, 32'd0);
    check_eq("rst_rsp_valid", {31'd0, bus0.rsp_valid}, 32'd0);
    check_eq("rst_rdata", bus0.rsp_rdata, 32'd0);
    check_eq("rst_done", {31'd0, bus0.done}, 32'd0);
    check_eq("rst_done_code", bus0.done_code, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("ready_after_rst", {31'd0, bus0.req_ready}, 32'd1);

    // Load after store, with latency
    access(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, rd, er, lt);
    check_eq("st_err", {31'd0, er}, 32'd0);
    check_eq("st_lat", lt, 32'd3);
    access(1'b0, 32'h10, 32'd0, 4'h0, rd, er, lt);
    check_eq("ld_data", rd, 32'hDEAD_BEEF);
    check_eq("ld_err", {31'd0, er}, 32'd0);
    check_eq("ld_lat", lt, 32'd3);

    // Partial store
    access(1'b1, 32'h10, 32'h0000_00AA, 4'h1, rd, er, lt);
    access(1'b0, 32'h10, 32'd0, 4'hF, rd, er, lt);
    check_eq("partial_data", rd, 32'hDEAD_BEAA);

    // Faults
    access(1'b0, 32'h12, 32'd0, 4'h0, rd, er, lt);
    check_eq("misalign_err", {31'd0, er}, 32'd1);
    check_eq("misalign_rdata", rd, 32'd0);
    access(1'b1, 32'h200, 32'h1234_5678, 4'hF, rd, er, lt);
    check_eq("range_err", {31'd0, er}, 32'd1);
    access(1'b1, 32'h1FC, 32'hCAFE_F00D, 4'hF, rd, er, lt);
    check_eq("last_word_err", {31'd0, er}, 32'd0);
    access(1'b0, 32'h10, 32'd0, 4'h0, rd, er, lt);
    check_eq("after_fault_data", rd, 32'hDEAD_BEAA);

    // Zero strobe store leaves data intact
    access(1'b1, 32'h10, 32'hFFFF_FFFF, 4'h0, rd, er, lt);
    check_eq("wstrb0_err", {31'd0, er}, 32'd0);
    access(1'b0, 32'h10, 32'd0, 4'h0, rd, er, lt);
    check_eq("wstrb0_data", rd, 32'hDEAD_BEAA);
    access(1'b0, 32'h1FC, 32'd0, 4'h0, rd, er, lt);
    check_eq("last_word_data", rd, 32'hCAFE_F00D);

    // Finish register
    check_eq("done_before", {31'd0, bus0.done}, 32'd0);
    access(1'b1, 32'd100, 32'd25, 4'h0, rd, er, lt);
    check_eq("done_set", {31'd0, bus0.done}, 32'd1);
    check_eq("done_code_25", bus0.done_code, 32'd25);
    access(1'b0, 32'd100, 32'd0, 4'h0, rd, er, lt);
    check_eq("done_load", rd, 32'd25);
    access(1'b1, 32'd100, 32'd7, 4'hF, rd, er, lt);
    check_eq("done_code_7", bus0.done_code, 32'd7);
    check_eq("done_sticky", {31'd0, bus0.done}, 32'd1);

    // Mid-operation reset aborts an in-flight store
    access(1'b1, 32'h20, 32'h1122_3344, 4'hF, rd, er, lt);
    @(negedge clk);
    bus0.req_valid = 1'b1; bus0.req_write = 1'b1; bus0.req_addr = 32'h20;
    bus0.req_wdata = 32'h55; bus0.req_wstrb = 4'hF;
    check_eq("abort_ready", {31'd0, bus0.req_ready}, 32'd1);
    @(posedge clk);
    #1;
    bus0.req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("abort_ready_in_rst", {31'd0, bus0.req_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("abort_ready_after", {31'd0, bus0.req_ready}, 32'd1);
    check_eq("abort_done_cleared", {31'd0, bus0.done}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      check_eq("abort_no_rsp", {31'd0, bus0.rsp_valid}, 32'd0);
      @(posedge clk);
      #1;
    end
    access(1'b0, 32'h20, 32'd0, 4'h0, rd, er, lt);
    check_eq("abort_prior_data", rd, 32'h1122_3344);
    access(1'b0, 32'h10, 32'd0, 4'h0, rd, er, lt);
    check_eq("mem_survives_rst", rd, 32'hDEAD_BEAA);

    // Zero-wait instance: back-to-back store then load every 2 cycles
    @(negedge clk);
    bus1.req_valid = 1'b1; bus1.req_write = 1'b1; bus1.req_addr = 32'h8;
    bus1.req_wdata = 32'h0000_1234; bus1.req_wstrb = 4'hF;
    check_eq("w0_ready0", {31'd0, bus1.req_ready}, 32'd1);
    @(negedge clk);
    check_eq("w0_ready1", {31'd0, bus1.req_ready}, 32'd0);
    check_eq("w0_rsp1", {31'd0, bus1.rsp_valid}, 32'd1);
    check_eq("w0_err1", {31'd0, bus1.rsp_error}, 32'd0);
    bus1.req_write = 1'b0;
    @(negedge clk);
    check_eq("w0_ready2", {31'd0, bus1.req_ready}, 32'd1);
    check_eq("w0_rsp2", {31'd0, bus1.rsp_valid}, 32'd0);
    @(negedge clk);
    check_eq("w0_rsp3", {31'd0, bus1.rsp_valid}, 32'd1);
    check_eq("w0_rdata3", bus1.rsp_rdata, 32'h0000_1234);
    bus1.req_valid = 1'b0;
    @(negedge clk);
    check_eq("w0_ready4", {31'd0, bus1.req_ready}, 32'd1);
    check_eq("w0_rsp4", {31'd0, bus1.rsp_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
